adau1761_cfg_sequencer: RTL and testbench
=========================================

// Module: adau1761_cfg_sequencer
// PURPOSE
//  Boot-time configuration controller for the ADAU1761 codec behind the I2S-style serial datapath.
//  - Walks a table of register writes and issues each one as an I2C write.
//  - Raises codec_ready so the serial sample streamer is released only after the codec is configured.
//  - Single clock domain. Write-only I2C master: open-drain, never clock-stretches, never reads.
// PARAMETERS
//  CLK_DIV     250    aclk cycles per quarter SCL period; 250 at 100 MHz gives 100 kHz SCL; must be >=2
//  DEV_ADDR    7'h38  7-bit codec I2C address; the write address byte is {DEV_ADDR,1'b0}
//  ROM_AW      6      table address width, up to 2**ROM_AW entries
//  POST_DELAY  1000   idle aclk cycles between the STOP of one entry and the START of the next
// PORTS
//  aclk         in   1       clock; all logic rising-edge
//  aresetn      in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse; begins the table walk from entry 0
//  rom_addr     out  ROM_AW  table index
//  rom_data     in   25      {last, reg_addr[15:0], reg_data[7:0]}; valid 1 cycle after rom_addr changes
//  scl_oe       out  1       1 = pull SCL low; 0 = release SCL
//  sda_oe       out  1       1 = pull SDA low; 0 = release SDA
//  sda_in       in   1       SDA pad value, already synchronised
//  busy         out  1       high from the start pulse until the DONE or ERR state
//  codec_ready  out  1       high in DONE; gates the serial streamer reset
//  error        out  1       high in ERR (NACK seen)
//  err_index    out  ROM_AW  table index of the NACKed entry
// BEHAVIOUR
//  Reset values: all outputs 0; both bus lines released; state IDLE.
//  States: IDLE -> FETCH -> START -> BYTE -> ACK -> (BYTE | STOP) -> GAP -> FETCH | DONE; any NACK -> STOP -> ERR.
//  Timing base
//   - Quarter tick every CLK_DIV cycles, counted from state entry.
//   - A bit lasts 4 quarters: q0 SCL low and drive SDA; q1 SCL low; q2 and q3 SCL released.
//  FETCH: present rom_addr, wait 1 cycle, latch rom_data.
//  START (4 quarters): q0-q1 SDA and SCL released; q2-q3 SDA low, SCL released.
//  Bytes: 4 per entry, MSB first, in this order:
//   {DEV_ADDR,0}, reg_addr[15:8], reg_addr[7:0], reg_data.
//  ACK: 9th bit with SDA released; sda_in is sampled at the last cycle of q2.
//   - sda_in = 1 is a NACK.
//   - On NACK: set err_index = rom_addr, then STOP -> ERR.
//  STOP (4 quarters): q0 SCL low, SDA low; q1 SCL released, SDA low; q2-q3 both released.
//  Entry length: 152 quarters (START 4 + 4 bytes x 36 + STOP 4), then GAP for POST_DELAY cycles.
//  After GAP:
//   - If the latched last = 1 -> DONE.
//   - Otherwise increment rom_addr -> FETCH.
//   - The last entry is always issued, so the table length is 1..2**ROM_AW.
//  rom_addr wrap: if rom_addr = 2**ROM_AW-1 and last = 0, treat the entry as last -> DONE (no wrap).
//  DONE: busy=0, codec_ready=1 until the next start.
//  ERR: busy=0, error=1, codec_ready=0 until the next start.
//  start handling
//   - In IDLE, DONE or ERR: clears error and codec_ready, sets rom_addr=0 and busy=1 on the next cycle, enters FETCH.
//   - While busy: start is ignored.
//  Reset mid-transaction: bus lines released immediately (async); no STOP is generated.
// TESTING
//  1. CLK_DIV=4, POST_DELAY=8, 1-entry table {1,16'h4000,8'h01}, slave model ACKs.
//     -> SDA bit stream 0x70,0x40,0x00,0x01 framed by START/STOP.
//     -> codec_ready rises 608+8 cycles after FETCH completes.
//  2. 3-entry table, last set on entry 2, all ACK.
//     -> exactly 3 transactions with GAP >= 8 cycles between them; rom_addr ends at 2; busy falls as codec_ready rises.
//  3. Slave NACKs reg_addr[7:0] of entry 1.
//     -> STOP is issued; error=1, err_index=1, codec_ready=0; no further START.
//  4. Pulse start during entry 0's data byte.
//     -> ignored; the transaction completes unchanged.
//     Then pulse start in ERR -> error clears and the walk restarts at entry 0.
//  5. Assert aresetn low mid-byte.
//     -> scl_oe=sda_oe=0 in the same cycle; all outputs 0; after release the block stays IDLE until start.
//  6. ROM_AW=2, 4-entry table with no last bit set.
//     -> exactly 4 transactions, then DONE; rom_addr never wraps to 0.

Source files
------------

// File: rtl/adau1761_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : adau1761_cfg_sequencer_if
// Purpose  : control, table-ROM and open-drain I2C pins of the codec boot sequencer
// Revision : 1.0
// ============================================================================
interface adau1761_cfg_sequencer_if #(
  parameter int ROM_AW = 6
);
  logic              start;
  logic [ROM_AW-1:0] rom_addr;
  logic [24:0]       rom_data;
  logic              scl_oe;
  logic              sda_oe;
  logic              sda_in;
  logic              busy;
  logic              codec_ready;
  logic              error;
  logic [ROM_AW-1:0] err_index;

  modport master (
    input  start, rom_data, sda_in,
    output rom_addr, scl_oe, sda_oe, busy, codec_ready, error, err_index
  );

  modport slave (
    output start, rom_data, sda_in,
    input  rom_addr, scl_oe, sda_oe, busy, codec_ready, error, err_index
  );
endinterface
`default_nettype wire

// File: rtl/adau1761_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adau1761_cfg_sequencer
// Purpose  : walks a register table and writes each entry to the ADAU1761 over I2C
// Revision : 1.0
// ============================================================================
module adau1761_cfg_sequencer #(
  parameter int         CLK_DIV    = 250,
  parameter logic [6:0] DEV_ADDR   = 7'h38,
  parameter int         ROM_AW     = 6,
  parameter int         POST_DELAY = 1000
) (
  input wire                       aclk,
  input wire                       aresetn,
  adau1761_cfg_sequencer_if.master bus
);

  localparam logic [3:0] c_idle  = 4'd0;
  localparam logic [3:0] c_fetch = 4'd1;
  localparam logic [3:0] c_start = 4'd2;
  localparam logic [3:0] c_byte  = 4'd3;
  localparam logic [3:0] c_ack   = 4'd4;
  localparam logic [3:0] c_stop  = 4'd5;
  localparam logic [3:0] c_gap   = 4'd6;
  localparam logic [3:0] c_done  = 4'd7;
  localparam logic [3:0] c_err   = 4'd8;

  localparam int c_cnt_max = (CLK_DIV > POST_DELAY) ? CLK_DIV : POST_DELAY;
  localparam int c_cw      = $clog2(c_cnt_max + 1);
  localparam logic [c_cw-1:0]   c_div_last = c_cw'(CLK_DIV - 1);
  localparam logic [c_cw-1:0]   c_gap_last = c_cw'(POST_DELAY - 1);
  localparam logic [c_cw-1:0]   c_cnt_one  = c_cw'(1);
  localparam logic [ROM_AW-1:0] c_addr_max = '1;
  localparam logic [ROM_AW-1:0] c_addr_one = ROM_AW'(1);

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [c_cw-1:0]   r_cnt;
  logic [1:0]        r_qtr;
  logic [2:0]        r_bit;
  logic [1:0]        r_byte;
  logic [24:0]       r_entry;
  logic              r_nack;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [ROM_AW-1:0] r_err_index;
  logic [7:0]        w_cur_byte;
  logic              w_tx_bit;
  logic              w_qend;
  logic              w_bend;
  logic              w_bus_state;
  logic              w_last_entry;
  logic              w_scl_oe;
  logic              w_sda_oe;

  assign w_qend       = (r_cnt == c_div_last);
  assign w_bend       = w_qend && (r_qtr == 2'd3);
  assign w_bus_state  = (r_state == c_start) || (r_state == c_byte) ||
                        (r_state == c_ack)   || (r_state == c_stop);
  // The final table slot always terminates the walk, so rom_addr never wraps.
  assign w_last_entry = r_entry[24] || (r_rom_addr == c_addr_max);

  always_comb begin
    case (r_byte)
      2'd0:    w_cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    w_cur_byte = r_entry[23:16];
      2'd2:    w_cur_byte = r_entry[15:8];
      default: w_cur_byte = r_entry[7:0];
    endcase
  end

  assign w_tx_bit = w_cur_byte[~r_bit];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= c_idle;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle, c_done, c_err: if (bus.start) w_next = c_fetch;
      c_fetch: if (r_cnt == c_cnt_one) w_next = c_start;
      c_start: if (w_bend) w_next = c_byte;
      c_byte:  if (w_bend && (r_bit == 3'd7)) w_next = c_ack;
      c_ack:   if (w_bend) w_next = (r_nack || (r_byte == 2'd3)) ? c_stop : c_byte;
      c_stop:  if (w_bend) w_next = r_nack ? c_err : c_gap;
      c_gap:   if (r_cnt == c_gap_last) w_next = w_last_entry ? c_done : c_fetch;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      c_start: w_sda_oe = r_qtr[1];
      c_byte: begin
        w_scl_oe = !r_qtr[1];
        w_sda_oe = !w_tx_bit;
      end
      c_ack:   w_scl_oe = !r_qtr[1];
      c_stop: begin
        w_scl_oe = (r_qtr == 2'd0);
        w_sda_oe = !r_qtr[1];
      end
      default: ;
    endcase
  end

  assign bus.scl_oe      = w_scl_oe;
  assign bus.sda_oe      = w_sda_oe;
  assign bus.busy        = (r_state != c_idle) && (r_state != c_done) && (r_state != c_err);
  assign bus.codec_ready = (r_state == c_done);
  assign bus.error       = (r_state == c_err);
  assign bus.rom_addr    = r_rom_addr;
  assign bus.err_index   = r_err_index;

  // Counters restart on every state change, so quarter ticks are aligned to state entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt       <= '0;
      r_qtr       <= 2'd0;
      r_bit       <= 3'd0;
      r_byte      <= 2'd0;
      r_entry     <= '0;
      r_nack      <= 1'b0;
      r_rom_addr  <= '0;
      r_err_index <= '0;
    end else begin
      if (r_state != w_next) begin
        r_cnt <= '0;
        r_qtr <= 2'd0;
      end else if (w_bus_state && w_qend) begin
        r_cnt <= '0;
        r_qtr <= r_qtr + 2'd1;
      end else if (w_bus_state || (r_state == c_fetch) || (r_state == c_gap)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end

      case (r_state)
        c_idle, c_done, c_err: if (bus.start) r_rom_addr <= '0;
        c_fetch: begin
          if (r_cnt == c_cnt_one) begin
            r_entry <= bus.rom_data;
            r_byte  <= 2'd0;
            r_bit   <= 3'd0;
            r_nack  <= 1'b0;
          end
        end
        c_byte: if (w_bend) r_bit <= r_bit + 3'd1;
        c_ack: begin
          if ((r_qtr == 2'd2) && w_qend) r_nack <= bus.sda_in;
          if (w_bend) begin
            if (r_nack) r_err_index <= r_rom_addr;
            else        r_byte      <= r_byte + 2'd1;
          end
        end
        c_gap: if (w_next == c_fetch) r_rom_addr <= r_rom_addr + c_addr_one;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adau1761_cfg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Bench: random register tables, I2C slave/bus monitor and byte/frame scoreboard.
module tb_adau1761_cfg_sequencer;
  localparam int         CLK_DIV       = 4;
  localparam int         POST_DELAY    = 8;
  localparam int         ROM_AW        = 2;
  localparam int         N_ROM         = 1 << ROM_AW;
  localparam logic [6:0] DEV_ADDR      = 7'h38;
  localparam int         ENTRY_CYCLES  = 152 * CLK_DIV;
  // From the START condition (SDA falls at START q2) to DONE: rest of the entry plus GAP.
  localparam int         START_TO_DONE = ENTRY_CYCLES - 2 * CLK_DIV + POST_DELAY;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  adau1761_cfg_sequencer_if #(.ROM_AW(ROM_AW)) bus ();

  adau1761_cfg_sequencer #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ADDR  (DEV_ADDR),
    .ROM_AW    (ROM_AW),
    .POST_DELAY(POST_DELAY)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge aclk) cyc++;

  logic [24:0] rom [N_ROM];
  always @(posedge aclk) bus.rom_data <= rom[bus.rom_addr];

  logic [7:0] exp_bytes [$];
  int         exp_frames[$];

  bit         ack_pull      = 1'b0;
  bit         prev_scl      = 1'b1;
  bit         prev_sda      = 1'b1;
  bit         in_frame      = 1'b0;
  int         nbits         = 0;
  int         nbytes        = 0;
  logic [7:0] shreg         = '0;
  int         n_starts      = 0;
  int         nack_start_no = -1;
  int         nack_byte_no  = -1;
  int         last_start_cyc = 0;
  int         last_stop_cyc  = -1;

  assign bus.sda_in = !(bus.sda_oe || ack_pull);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // I2C slave + monitor: decodes START/STOP/bits on the open-drain lines, ACKs bytes.
  always @(negedge aclk) begin
    bit         scl;
    bit         sda;
    logic [8:0] eb;
    int         ef;
    scl = !bus.scl_oe;
    sda = !(bus.sda_oe || ack_pull);
    if (!aresetn) begin
      in_frame      = 1'b0;
      ack_pull      = 1'b0;
      nbits         = 0;
      last_stop_cyc = -1;
      scl           = 1'b1;
      sda           = 1'b1;
    end else if (prev_scl && scl && prev_sda && !sda) begin
      n_starts++;
      check("start_was_expected", exp_frames.size() != 0, 1);
      if (last_stop_cyc >= 0)
        check("stop_to_start_min_gap", (cyc - last_stop_cyc) >= (POST_DELAY + 4 * CLK_DIV), 1);
      in_frame       = 1'b1;
      nbits          = 0;
      nbytes         = 0;
      last_start_cyc = cyc;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      ef = (exp_frames.size() != 0) ? exp_frames.pop_front() : -1;
      check("frame_byte_count", nbytes, ef);
      in_frame      = 1'b0;
      last_stop_cyc = cyc;
    end else if (in_frame && !prev_scl && scl) begin
      if (nbits < 8) shreg = {shreg[6:0], sda};
      nbits++;
    end else if (in_frame && prev_scl && !scl) begin
      if (nbits == 8) begin
        eb = (exp_bytes.size() != 0) ? {1'b0, exp_bytes.pop_front()} : 9'h1FF;
        check("sda_byte", {1'b0, shreg}, eb);
        ack_pull = !((n_starts == nack_start_no) && (nbytes == nack_byte_no));
        nbytes++;
      end else if (nbits == 9) begin
        ack_pull = 1'b0;
        nbits    = 0;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic fill_table(input int n_entries);
    logic [31:0] rnd;
    for (int i = 0; i < N_ROM; i++) begin
      rnd    = $urandom();
      rom[i] = {(n_entries > 0) && (i == n_entries - 1), rnd[23:0]};
    end
  endtask

  // Reference model: the byte stream and frame lengths the table walk should produce.
  task automatic load_expect(input int nack_e, input int nack_b, output bit exp_err, output int exp_idx);
    exp_err = 1'b0;
    exp_idx = N_ROM - 1;
    for (int e = 0; e < N_ROM; e++) begin
      logic [7:0] b [4];
      int         nb;
      b[0] = {DEV_ADDR, 1'b0};
      b[1] = rom[e][23:16];
      b[2] = rom[e][15:8];
      b[3] = rom[e][7:0];
      nb   = (e == nack_e) ? nack_b + 1 : 4;
      for (int k = 0; k < nb; k++) exp_bytes.push_back(b[k]);
      exp_frames.push_back(nb);
      if (e == nack_e) begin exp_err = 1'b1; exp_idx = e; break; end
      if (rom[e][24]) begin exp_idx = e; break; end
    end
  endtask

  task automatic pulse_start();
    @(negedge aclk);
    bus.start = 1'b1;
    @(negedge aclk);
    bus.start = 1'b0;
  endtask

  task automatic run_walk(input int nack_e, input int nack_b, input bit extra_start);
    bit exp_err;
    int exp_idx;
    bit got_done;
    nack_start_no = (nack_e >= 0) ? n_starts + nack_e + 1 : -1;
    nack_byte_no  = nack_b;
    load_expect(nack_e, nack_b, exp_err, exp_idx);
    pulse_start();
    check("busy_after_start", bus.busy, 1);
    check("error_after_start", bus.error, 0);
    check("ready_after_start", bus.codec_ready, 0);
    check("rom_addr_after_start", bus.rom_addr, 0);
    if (extra_start) begin
      repeat (112 * CLK_DIV + 2 + $urandom_range(0, 30 * CLK_DIV)) @(negedge aclk);
      pulse_start();
    end
    got_done = 1'b0;
    for (int c = 0; c < 8 * N_ROM * ENTRY_CYCLES; c++) begin
      @(negedge aclk);
      if (!bus.busy) begin got_done = 1'b1; break; end
    end
    check("walk_finished", got_done, 1);
    check("codec_ready_final", bus.codec_ready, !exp_err);
    check("error_final", bus.error, exp_err);
    check("rom_addr_final", bus.rom_addr, exp_idx);
    if (exp_err) check("err_index", bus.err_index, exp_idx);
    else         check("start_to_ready_cycles", cyc - last_start_cyc, START_TO_DONE);
    check("bytes_left", exp_bytes.size(), 0);
    check("frames_left", exp_frames.size(), 0);
    repeat (20 * CLK_DIV) @(negedge aclk);
    check("bus_released_after", {bus.scl_oe, bus.sda_oe}, 0);
    check("state_held", {bus.busy, bus.codec_ready, bus.error}, {1'b0, !exp_err, exp_err});
  endtask

  task automatic reset_mid_byte();
    bit exp_err;
    int exp_idx;
    bit seen;
    fill_table(N_ROM);
    nack_start_no = -1;
    load_expect(-1, 0, exp_err, exp_idx);
    pulse_start();
    repeat (40 * CLK_DIV) @(negedge aclk);
    seen = 1'b0;
    for (int c = 0; c < 4 * CLK_DIV; c++) begin
      if (bus.scl_oe) begin seen = 1'b1; break; end
      @(negedge aclk);
    end
    check("scl_low_before_reset", seen, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_scl_oe", bus.scl_oe, 0);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.codec_ready, bus.error}, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_err_index", bus.err_index, 0);
    exp_bytes.delete();
    exp_frames.delete();
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (40 * CLK_DIV) @(negedge aclk);
    check("idle_after_reset_busy", bus.busy, 0);
    check("idle_after_reset_bus", {bus.scl_oe, bus.sda_oe}, 0);
  endtask

  initial begin
    int n;
    int ne;
    int nb;
    bus.start = 1'b0;
    for (int i = 0; i < N_ROM; i++) rom[i] = '0;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_scl_oe", bus.scl_oe, 0);
    check("reset_sda_oe", bus.sda_oe, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_codec_ready", bus.codec_ready, 0);
    check("reset_error", bus.error, 0);
    check("reset_rom_addr", bus.rom_addr, 0);
    check("reset_err_index", bus.err_index, 0);
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);

    fill_table(0);
    rom[0] = {1'b1, 16'h4000, 8'h01};
    run_walk(-1, 0, 1'b0);

    fill_table(3);
    run_walk(-1, 0, 1'b1);

    fill_table(3);
    run_walk(1, 2, 1'b0);

    fill_table(2);
    run_walk(-1, 0, 1'b1);

    reset_mid_byte();

    fill_table(0);
    run_walk(-1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, N_ROM);
      fill_table(n);
      ne = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      nb = $urandom_range(0, 3);
      run_walk(ne, nb, (ne != 0) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
